jtag_regbank: RTL and testbench
===============================

# jtag_regbank

Addressed, bidirectional JTAG data-register bridge from the TCK domain into the `sysclk` domain. It is the parametrised successor of the single-word JTAG register. One user-DR scan carries an opcode, an address and a data word. Writes become single-cycle strobes; reads become a request/acknowledge transaction whose result is returned on the next scan's capture. It sits between the TAP primitive (`tck`/`tdi`/`sel`/`shift`/`update`) and a system-side register file or bus.

## Interface
- `addr_bits`, default 4: address field width, 1..16.
- `data_bits`, default 32: data field width, 1..64.
- F = 1 + `addr_bits` + `data_bits`: frame length in bits (derived).

- `sysclk` in 1: system clock. All logic is clocked here.
- `reset_n` in 1: asynchronous, active-low reset.
- `tck`, `tdi`, `sel`, `shift`, `update` in 1 each: raw TAP signals, asynchronous to `sysclk`.
- `tdo` out 1: serial output, LSB first.
- `wr_stb` out 1: one-cycle write strobe.
- `wr_addr` out `addr_bits`: write address.
- `wr_data` out `data_bits`: write data.
- `rd_req` out 1: read request; held high until acknowledged.
- `rd_addr` out `addr_bits`: read address.
- `rd_ack` in 1: read acknowledge; `rd_data` is valid in the same cycle.
- `rd_data` in `data_bits`: read data.
- `cmd_drop` out 1: one-cycle pulse when a command is discarded.

One clock; reset is asynchronous and active-low.

## Operation

**TCK edge detection**
- `tck` passes through a 3-flop synchroniser.
- `tck_p` and `tck_n` are decoded from stages [2:1]. All TAP-side actions occur only in cycles where `tck_p` is high.

**Frame layout**
- Shift register `sr` is F bits wide.
- Bit 0 is `op` (1 = write, 0 = read). Bits [`addr_bits`:1] are the address. The top `data_bits` bits are the data.

**TAP-side behaviour, on `tck_p`**
- Capture: when `sel` is high and `shift` is low, `sr` loads {`buf_data`, `buf_addr`, `buf_valid`}.
- Shift: when `sel` and `shift` are both high, `tdo` takes `sr[0]` and `sr` shifts right with `tdi` entering the MSB.
- `shift_d` registers `shift` on every `tck_p`.
- While `shift_d` is high, `tdi` is also captured into `tdi_l`.
- `selected` takes `sel` whenever `shift` is high.

**Command decode**
- The command word is {`tdi_l`, `sr[F-1:1]`}, taken on the first `tck_p` with `update` high while `selected` is set.
- The top bit (`tdi_l`) is the bit presented on the shift-exit edge.

**Command execution**
- Write (`op` = 1):
  - `wr_addr` and `wr_data` are loaded and `wr_stb` pulses for one cycle.
  - `wr_addr` and `wr_data` hold their values until the next write.
- Read (`op` = 0), when FSM is IDLE:
  - `rd_addr` is loaded, `rd_req` rises, `buf_valid` clears, and the FSM goes IDLE→WAIT.
- Read completion, in WAIT with `rd_ack` high:
  - `buf_data` takes `rd_data`, `buf_addr` takes `rd_addr`, and `buf_valid` is set.
  - `rd_req` falls in the next cycle and the FSM goes WAIT→IDLE.
- Any command (read or write) decoded while in WAIT is discarded and `cmd_drop` pulses.
- `rd_ack` seen in IDLE is ignored.

**Simultaneous events**
- If capture and `rd_ack` fall in the same cycle, capture takes the old buffer value and the buffer updates afterwards.
- `buf_valid` stays set until the next accepted read.

## Timing
- Reset values: `tdo`, `wr_stb`, `rd_req`, `cmd_drop` = 0; `wr_addr`, `wr_data`, `rd_addr` = 0. Internally, `sr`, the buffer, `buf_valid`, the synchroniser, `shift_d`, `tdi_l` and `selected` are all 0, and the FSM is IDLE.
- Edge latency: a `tck` rising edge yields `tck_p` 2–3 `sysclk` cycles later.
- Requirement: `sysclk` ≥ 4× the `tck` frequency.
- `tdo` changes one cycle after `tck_p`.
- Write latency: `wr_stb` is high exactly one cycle, in the cycle after the decoding `tck_p`.
- Read latency: `rd_req` rises one cycle after the decoding `tck_p`. `rd_ack` may come in the same cycle `rd_req` is first seen high, or any number of cycles later.
- Reset asserted mid-read: `rd_req` drops immediately (asynchronously) and any late `rd_ack` is ignored.
- A frame shorter or longer than F bits is not detected. The last F bits shifted are what gets decoded.

## Test plan
- **Write:** `addr_bits`=4, `data_bits`=32; scan a write to addr 5 with data 0xDEADBEEF (op=1) → exactly one `wr_stb` pulse, `wr_addr`=5, `wr_data`=0xDEADBEEF, no `rd_req`.
- **Read with delayed ack:** scan a read of addr 3; drive `rd_ack` 7 cycles after `rd_req` with `rd_data`=0x12345678. On the next scan, the `tdo` stream LSB-first is 1, then 3 (4 bits), then 0x12345678.
- **Capture before completion:** capture occurs before `rd_ack` → shifted-out bit 0 is 0; a later scan after the ack shows valid=1.
- **Command while busy:** second command (write addr 9) while in WAIT → `cmd_drop` pulses once, no `wr_stb`; the pending read still completes normally.
- **Reset mid-read:** assert `reset_n` low while `rd_req` is high → `rd_req`=0 immediately. After release, `rd_ack` is ignored and the next capture returns an all-zero frame.
- **Slow-clock ratio:** `tck` = `sysclk`/4 with random `tdi` across 100 back-to-back writes → every strobe matches the scanned frame and `tck_n` never triggers any action.

Source files
------------

// File: rtl/jtag_regbank_if.sv
// System-side bus of the JTAG register bridge: write strobe with address/data
// and a read request/acknowledge handshake.
interface jtag_regbank_if #(
  parameter int addr_bits = 4,
  parameter int data_bits = 32
) ();
  logic                 wr_stb;
  logic [addr_bits-1:0] wr_addr;
  logic [data_bits-1:0] wr_data;
  logic                 rd_req;
  logic [addr_bits-1:0] rd_addr;
  logic                 rd_ack;
  logic [data_bits-1:0] rd_data;

  modport master (
    output wr_stb, wr_addr, wr_data, rd_req, rd_addr,
    input  rd_ack, rd_data
  );

  modport slave (
    input  wr_stb, wr_addr, wr_data, rd_req, rd_addr,
    output rd_ack, rd_data
  );
endinterface

// File: rtl/jtag_regbank.sv
// Addressed JTAG user-DR bridge into the sysclk domain: TAP signals are
// oversampled, one scan frame = {data, addr, op}; reads return on the next capture.
module jtag_regbank #(
  parameter int addr_bits = 4,
  parameter int data_bits = 32
) (
  input  logic           sysclk,
  input  logic           reset_n,
  input  logic           tck,
  input  logic           tdi,
  input  logic           sel,
  input  logic           shift,
  input  logic           update,
  output logic           tdo,
  output logic           cmd_drop,
  jtag_regbank_if.master bus
);
  localparam int frame_bits = 1 + addr_bits + data_bits;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  logic [2:0]            tck_sync_r;
  logic                  tck_p_s;
  logic [frame_bits-1:0] sr_r;
  logic                  shift_d_r;
  logic                  tdi_l_r;
  logic                  selected_r;
  logic                  tdo_r;

  logic                  decode_s;
  logic [frame_bits-1:0] cmd_s;
  logic                  cmd_op_s;
  logic [addr_bits-1:0]  cmd_addr_s;
  logic [data_bits-1:0]  cmd_data_s;

  state_t                state_r;
  state_t                state_nxt_s;
  logic                  wr_stb_r;
  logic                  wr_stb_nxt_s;
  logic [addr_bits-1:0]  wr_addr_r;
  logic [addr_bits-1:0]  wr_addr_nxt_s;
  logic [data_bits-1:0]  wr_data_r;
  logic [data_bits-1:0]  wr_data_nxt_s;
  logic                  rd_req_r;
  logic                  rd_req_nxt_s;
  logic [addr_bits-1:0]  rd_addr_r;
  logic [addr_bits-1:0]  rd_addr_nxt_s;
  logic                  cmd_drop_r;
  logic                  cmd_drop_nxt_s;
  logic [data_bits-1:0]  buf_data_r;
  logic [data_bits-1:0]  buf_data_nxt_s;
  logic [addr_bits-1:0]  buf_addr_r;
  logic [addr_bits-1:0]  buf_addr_nxt_s;
  logic                  buf_valid_r;
  logic                  buf_valid_nxt_s;

  // Rising TCK edge as seen after the synchroniser; falling edges are never acted on.
  assign tck_p_s = tck_sync_r[1] & ~tck_sync_r[2];

  // The last frame bit arrives on the shift-exit edge and lives in tdi_l_r.
  assign cmd_s      = {tdi_l_r, sr_r[frame_bits-1:1]};
  assign cmd_op_s   = cmd_s[0];
  assign cmd_addr_s = cmd_s[addr_bits:1];
  assign cmd_data_s = cmd_s[frame_bits-1:addr_bits+1];
  assign decode_s   = tck_p_s & update & selected_r;

  assign tdo         = tdo_r;
  assign cmd_drop    = cmd_drop_r;
  assign bus.wr_stb  = wr_stb_r;
  assign bus.wr_addr = wr_addr_r;
  assign bus.wr_data = wr_data_r;
  assign bus.rd_req  = rd_req_r;
  assign bus.rd_addr = rd_addr_r;

  // Three-stage TCK synchroniser.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      tck_sync_r <= 3'b000;
    end else begin
      tck_sync_r <= {tck_sync_r[1:0], tck};
    end
  end

  // TAP-side capture/shift register and shift-exit tracking, advanced on tck_p only.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      sr_r       <= '0;
      shift_d_r  <= 1'b0;
      tdi_l_r    <= 1'b0;
      selected_r <= 1'b0;
      tdo_r      <= 1'b0;
    end else if (tck_p_s) begin
      shift_d_r <= shift;
      if (shift_d_r) begin
        tdi_l_r <= tdi;
      end
      // Clearing on decode makes only the first update edge of a scan count.
      if (shift) begin
        selected_r <= sel;
      end else if (decode_s) begin
        selected_r <= 1'b0;
      end
      if (sel && !shift) begin
        sr_r <= {buf_data_r, buf_addr_r, buf_valid_r};
      end else if (sel && shift) begin
        tdo_r <= sr_r[0];
        sr_r  <= {tdi, sr_r[frame_bits-1:1]};
      end
    end
  end

  // Command execution and read-handshake state, next values.
  always_comb begin
    state_nxt_s     = state_r;
    wr_stb_nxt_s    = 1'b0;
    wr_addr_nxt_s   = wr_addr_r;
    wr_data_nxt_s   = wr_data_r;
    rd_req_nxt_s    = rd_req_r;
    rd_addr_nxt_s   = rd_addr_r;
    cmd_drop_nxt_s  = 1'b0;
    buf_data_nxt_s  = buf_data_r;
    buf_addr_nxt_s  = buf_addr_r;
    buf_valid_nxt_s = buf_valid_r;
    case (state_r)
      ST_IDLE: begin
        if (decode_s) begin
          if (cmd_op_s) begin
            wr_stb_nxt_s  = 1'b1;
            wr_addr_nxt_s = cmd_addr_s;
            wr_data_nxt_s = cmd_data_s;
          end else begin
            rd_addr_nxt_s   = cmd_addr_s;
            rd_req_nxt_s    = 1'b1;
            buf_valid_nxt_s = 1'b0;
            state_nxt_s     = ST_WAIT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (decode_s) begin
          cmd_drop_nxt_s = 1'b1;
        end else begin
          cmd_drop_nxt_s = 1'b0;
        end
        if (bus.rd_ack) begin
          buf_data_nxt_s  = bus.rd_data;
          buf_addr_nxt_s  = rd_addr_r;
          buf_valid_nxt_s = 1'b1;
          rd_req_nxt_s    = 1'b0;
          state_nxt_s     = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        rd_req_nxt_s = 1'b0;
        state_nxt_s  = ST_IDLE;
      end
    endcase
  end

  // Command execution and read-handshake state, registers.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      wr_stb_r    <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= '0;
      rd_req_r    <= 1'b0;
      rd_addr_r   <= '0;
      cmd_drop_r  <= 1'b0;
      buf_data_r  <= '0;
      buf_addr_r  <= '0;
      buf_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      wr_stb_r    <= wr_stb_nxt_s;
      wr_addr_r   <= wr_addr_nxt_s;
      wr_data_r   <= wr_data_nxt_s;
      rd_req_r    <= rd_req_nxt_s;
      rd_addr_r   <= rd_addr_nxt_s;
      cmd_drop_r  <= cmd_drop_nxt_s;
      buf_data_r  <= buf_data_nxt_s;
      buf_addr_r  <= buf_addr_nxt_s;
      buf_valid_r <= buf_valid_nxt_s;
    end
  end
endmodule

// File: tb/tb_jtag_regbank.sv
// Directed bench for jtag_regbank: scans frames through a modelled TAP and
// checks strobes, read handshake, capture frames, drops and reset behaviour.
module tb_jtag_regbank;
  localparam int AB = 4;
  localparam int DB = 32;
  localparam int FB = 1 + AB + DB;

  logic sysclk  = 1'b0;
  logic reset_n = 1'b0;
  logic tck     = 1'b0;
  logic tdi     = 1'b0;
  logic sel     = 1'b0;
  logic shift   = 1'b0;
  logic update  = 1'b0;
  logic tdo;
  logic cmd_drop;

  int half_cyc  = 4;
  int check_cnt = 0;
  int err_cnt   = 0;
  int wr_cnt    = 0;
  int drop_cnt  = 0;
  int rdreq_cyc = 0;
  logic [AB-1:0] seen_addr = '0;
  logic [DB-1:0] seen_data = '0;

  jtag_regbank_if #(.addr_bits(AB), .data_bits(DB)) bus ();

  jtag_regbank #(.addr_bits(AB), .data_bits(DB)) dut (
    .sysclk   (sysclk),
    .reset_n  (reset_n),
    .tck      (tck),
    .tdi      (tdi),
    .sel      (sel),
    .shift    (shift),
    .update   (update),
    .tdo      (tdo),
    .cmd_drop (cmd_drop),
    .bus      (bus)
  );

  always #5 sysclk = ~sysclk;

  // Record strobes, drops and read-request activity away from the active edge.
  always @(negedge sysclk) begin
    if (bus.wr_stb === 1'b1) begin
      wr_cnt    <= wr_cnt + 1;
      seen_addr <= bus.wr_addr;
      seen_data <= bus.wr_data;
    end
    if (cmd_drop === 1'b1) drop_cnt <= drop_cnt + 1;
    if (bus.rd_req === 1'b1) rdreq_cyc <= rdreq_cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FB-1:0] frame(input logic op, input logic [AB-1:0] a,
                                          input logic [DB-1:0] d);
    return {d, a, op};
  endfunction

  // One TCK period; inputs change together with the rising edge, tdo sampled at the end.
  task automatic tap_edge(input logic s_sel, input logic s_shift, input logic s_upd,
                          input logic s_tdi, output logic tdo_o);
    sel = s_sel; shift = s_shift; update = s_upd; tdi = s_tdi;
    tck = 1'b1;
    repeat (half_cyc) @(negedge sysclk);
    tck = 1'b0;
    repeat (half_cyc) @(negedge sysclk);
    tdo_o = tdo;
  endtask

  // Capture, FB shift edges (one pad bit then cmd[0..FB-2]), exit edge with cmd[FB-1], update.
  task automatic scan(input logic [FB-1:0] cmd, output logic [FB-1:0] cap);
    logic b;
    tap_edge(1'b1, 1'b0, 1'b0, 1'b0, b);
    for (int k = 0; k < FB; k++) begin
      tap_edge(1'b1, 1'b1, 1'b0, (k == 0) ? 1'b0 : cmd[k-1], b);
      cap[k] = b;
    end
    tap_edge(1'b0, 1'b0, 1'b0, cmd[FB-1], b);
    tap_edge(1'b0, 1'b0, 1'b1, 1'b0, b);
    tap_edge(1'b0, 1'b0, 1'b0, 1'b0, b);
  endtask

  task automatic give_ack(input int delay, input logic [DB-1:0] d);
    repeat (delay) @(negedge sysclk);
    bus.rd_data = d;
    bus.rd_ack  = 1'b1;
    @(negedge sysclk);
    bus.rd_ack  = 1'b0;
  endtask

  initial begin
    logic [FB-1:0] cap;
    int w0, d0, r0;
    logic [AB-1:0] ra;
    logic [DB-1:0] rd;
    bus.rd_ack  = 1'b0;
    bus.rd_data = '0;
    repeat (3) @(negedge sysclk);
    reset_n = 1'b1;
    @(negedge sysclk);

    chk("rst_tdo", tdo, 64'd0);
    chk("rst_wr_stb", bus.wr_stb, 64'd0);
    chk("rst_rd_req", bus.rd_req, 64'd0);
    chk("rst_cmd_drop", cmd_drop, 64'd0);
    chk("rst_wr_addr", bus.wr_addr, 64'd0);
    chk("rst_wr_data", bus.wr_data, 64'd0);
    chk("rst_rd_addr", bus.rd_addr, 64'd0);

    // Write addr 5, data DEADBEEF
    w0 = wr_cnt; r0 = rdreq_cyc;
    scan(frame(1'b1, 4'd5, 32'hDEADBEEF), cap);
    chk("rst_capture", cap, 64'd0);
    chk("wr_count", wr_cnt - w0, 64'd1);
    chk("wr_addr", bus.wr_addr, 64'd5);
    chk("wr_data", bus.wr_data, 64'hDEADBEEF);
    chk("wr_stb_data", seen_data, 64'hDEADBEEF);
    chk("wr_no_rd_req", rdreq_cyc - r0, 64'd0);

    // Read addr 3 with ack 7 cycles later
    scan(frame(1'b0, 4'd3, 32'h0), cap);
    chk("rd_req_up", bus.rd_req, 64'd1);
    chk("rd_addr", bus.rd_addr, 64'd3);
    give_ack(7, 32'h12345678);
    chk("rd_req_down", bus.rd_req, 64'd0);
    chk("wr_addr_hold", bus.wr_addr, 64'd5);
    scan(frame(1'b1, 4'hA, 32'h0BADF00D), cap);
    chk("rd_frame", cap, {27'd0, 32'h12345678, 4'h3, 1'b1});
    chk("wr2_data", bus.wr_data, 64'h0BADF00D);

    // Capture before completion, plus a command while busy
    scan(frame(1'b0, 4'd7, 32'h0), cap);
    chk("valid_persist", cap, {27'd0, 32'h12345678, 4'h3, 1'b1});
    chk("rd7_req", bus.rd_req, 64'd1);
    d0 = drop_cnt; w0 = wr_cnt;
    scan(frame(1'b1, 4'd9, 32'h55AA55AA), cap);
    chk("busy_capture", cap, {27'd0, 32'h12345678, 4'h3, 1'b0});
    chk("busy_drop", drop_cnt - d0, 64'd1);
    chk("busy_no_wr", wr_cnt - w0, 64'd0);
    chk("busy_wr_addr", bus.wr_addr, 64'hA);
    chk("busy_rd_req", bus.rd_req, 64'd1);
    give_ack(0, 32'hCAFEF00D);
    chk("busy_rd_done", bus.rd_req, 64'd0);
    scan(frame(1'b1, 4'd2, 32'h11111111), cap);
    chk("busy_rd_frame", cap, {27'd0, 32'hCAFEF00D, 4'h7, 1'b1});
    chk("busy_drop_once", drop_cnt - d0, 64'd1);
    chk("wr3_addr", bus.wr_addr, 64'd2);

    // Ack while idle is ignored
    give_ack(0, 32'hFFFFFFFF);
    scan(frame(1'b1, 4'd2, 32'h22222222), cap);
    chk("idle_ack_ignored", cap, {27'd0, 32'hCAFEF00D, 4'h7, 1'b1});

    // Reset mid-read
    scan(frame(1'b0, 4'hC, 32'h0), cap);
    chk("rstrd_req_up", bus.rd_req, 64'd1);
    @(negedge sysclk);
    reset_n = 1'b0;
    #1;
    chk("rstrd_req_async", bus.rd_req, 64'd0);
    chk("rstrd_wr_addr", bus.wr_addr, 64'd0);
    repeat (2) @(negedge sysclk);
    reset_n = 1'b1;
    @(negedge sysclk);
    give_ack(0, 32'hFFFFFFFF);
    chk("rstrd_late_ack", bus.rd_req, 64'd0);
    scan(frame(1'b1, 4'd4, 32'h0), cap);
    chk("rstrd_zero_frame", cap, 64'd0);

    // Back-to-back random writes with tck = sysclk/4
    half_cyc = 2;
    for (int n = 0; n < 100; n++) begin
      ra = AB'($urandom_range(15, 0));
      rd = $urandom;
      w0 = wr_cnt;
      scan(frame(1'b1, ra, rd), cap);
      chk("slow_wr_count", wr_cnt - w0, 64'd1);
      chk("slow_wr_addr", seen_addr, {60'd0, ra});
      chk("slow_wr_data", seen_data, {32'd0, rd});
      chk("slow_capture", cap, 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end
endmodule
